// File: rtl/display_7s_pkg.sv
// Shared constants, field layout and scan FSM encoding for the 8-digit 7-segment scanner.
package display_7s_pkg;

  localparam int N_DIGITS  = 8;
  localparam int DIGIT_W   = 10;
  localparam int IDX_W     = $clog2(N_DIGITS);

  localparam int SEG_LSB   = 0;
  localparam int DP_BIT    = 7;
  localparam int EN_BIT    = 8;
  localparam int BLINK_BIT = 9;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Active-low cathode pattern {DP,G,F,E,D,C,B,A} for one digit field.
  function automatic logic [7:0] seg_pattern(input logic [DIGIT_W-1:0] d);
    return ~{d[DP_BIT], d[SEG_LSB +: 7]};
  endfunction

endpackage

// File: rtl/display_7s_tick.sv
// Modulo-N counter with a single-cycle wrap pulse on the enabled count of N-1.
module display_7s_tick #(
  parameter int N = 10,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/display_7s_scan.sv
// Time-multiplexed driver for an 8-digit common-anode display with inter-digit blanking.
// Define DIS_BLINK_EN to build the per-digit blink feature (bit 9 of each digit field).
module display_7s_scan
  import display_7s_pkg::*;
#(
  parameter int DIGIT_TICKS  = 100000,
  parameter int BLANK_TICKS  = 1000,
  parameter int BLINK_FRAMES = 62
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_DIGITS*DIGIT_W-1:0]   dis_data,
  output logic [7:0]                    seg,
  output logic [7:0]                    an,
  output logic                          frame_start,
  output scan_state_t                   scan_state
);

  localparam int CNT_W = $clog2(DIGIT_TICKS);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);

  logic [CNT_W-1:0]              slot_cnt;
  logic                          slot_wrap;
  logic [IDX_W-1:0]              idx_q;
  logic [N_DIGITS*DIGIT_W-1:0]   frame_q;
  logic                          frame_sample;
  scan_state_t                   state_q, state_d;
  logic [DIGIT_W-1:0]            cur_digit;
  logic                          blink_dark;
  logic                          dark;
  logic [7:0]                    an_d, seg_d;

  display_7s_tick #(
    .N (DIGIT_TICKS),
    .W (CNT_W)
  ) u_slot (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .count (slot_cnt),
    .wrap  (slot_wrap)
  );

  // Counter 0 of digit 0 occurs exactly once per frame, including the first cycle out of reset.
  assign frame_sample = (slot_cnt == '0) && (idx_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      if (slot_wrap) idx_q <= idx_q + 1'b1;
      if (frame_sample) frame_q <= dis_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= BLANK;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (slot_cnt == BLANK_LAST) state_d = DRIVE;
      DRIVE:   if (slot_wrap) state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  assign scan_state = state_q;
  assign cur_digit  = frame_q[int'(idx_q) * DIGIT_W +: DIGIT_W];

`ifdef DIS_BLINK_EN
  localparam int BL_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic            started_q;
  logic            blink_phase_q;
  logic            blink_wrap;
  logic [BL_W-1:0] unused_blink_cnt;

  // The sample right after reset opens frame 0; only later frame starts advance the blink count.
  display_7s_tick #(
    .N (BLINK_FRAMES),
    .W (BL_W)
  ) u_blink (
    .clk   (clk),
    .reset (reset),
    .en    (frame_sample & started_q),
    .count (unused_blink_cnt),
    .wrap  (blink_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      started_q     <= 1'b0;
      blink_phase_q <= 1'b0;
    end else begin
      if (frame_sample) started_q <= 1'b1;
      if (blink_wrap) blink_phase_q <= ~blink_phase_q;
    end
  end

  assign blink_dark = blink_phase_q & cur_digit[BLINK_BIT];
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_blink_req;

  assign unused_blink_req = cur_digit[BLINK_BIT];
  assign blink_dark       = 1'b0;
`endif

  assign dark = ~cur_digit[EN_BIT] | blink_dark;

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (state_q == DRIVE) begin
      seg_d = seg_pattern(cur_digit);
      if (!dark) an_d = ~(8'd1 << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      an          <= an_d;
      seg         <= seg_d;
      frame_start <= frame_sample;
    end
  end

endmodule
